// File: rtl/result_serializer_if.sv
// -----------------------------------------------------------------------------
// result_serializer_if
//   Bundle of the handshake and serial-line signals of result_serializer.
//
//   Handshake: a word is transferred on a rising clk edge where start=1 and
//   ready=1 together; start while ready=0 is dropped (no queuing), and data_in
//   only matters on that accepting edge. ready stays low from the accept until
//   the cycle after done.
//
//   Signals
//     start       master -> slave   request transmission
//     data_in     master -> slave   WIDTH-bit result word
//     ready       slave  -> master  serializer idle
//     ser_out     slave  -> master  serial data, MSB first
//     ser_frame   slave  -> master  ser_out carries a valid bit
//     bit_strobe  slave  -> master  first cycle of each bit
//     done        slave  -> master  one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
interface result_serializer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             ser_out;
    logic             ser_frame;
    logic             bit_strobe;
    logic             done;

    modport master (
        output start,
        output data_in,
        input  ready,
        input  ser_out,
        input  ser_frame,
        input  bit_strobe,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output ready,
        output ser_out,
        output ser_frame,
        output bit_strobe,
        output done
    );
endinterface

// File: rtl/result_serializer.sv
// -----------------------------------------------------------------------------
// result_serializer
//   Captures a WIDTH-bit result word and shifts it out MSB-first on one pin,
//   qualified by ser_frame. Each bit is held CLK_DIV clocks; bit_strobe marks
//   the first clock of every bit and done pulses once after the last bit.
//   The bit order matches an input deserializer that shifts new bits in at
//   the LSB, so a loopback rebuilds data_in.
//
//   Optional feature macro: SER_PARITY_EN
//     defined   -> one extra even-parity bit follows the data LSB
//     undefined -> plain WIDTH-bit frame, no parity logic
//
//   Ports
//     clk          in   system clock, all state on posedge
//     rst_n        in   asynchronous active-low reset
//     bus          slave modport of result_serializer_if
//                  (start, data_in, ready, ser_out, ser_frame, bit_strobe, done)
//     dbg_state_o  out  current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
//   All outputs come straight from flops, so start and data_in never reach an
//   output combinationally.
// -----------------------------------------------------------------------------
module result_serializer #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    result_serializer_if.slave  bus,
    output logic [1:0]          dbg_state_o
);

`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(NBITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [NBITS-1:0]   shreg_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic               ready_q;
    logic               ser_out_q;
    logic               frame_q;
    logic               strobe_q;
    logic               done_q;

    // Word as it enters the shift register. With parity the parity bit sits
    // below the data LSB, so it simply falls out as the final bit.
    logic [NBITS-1:0]   load_w;

`ifdef SER_PARITY_EN
    assign load_w = {bus.data_in, ^bus.data_in};
`else
    assign load_w = bus.data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            ready_q   <= 1'b1;
            ser_out_q <= 1'b0;
            frame_q   <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q   <= ST_SHIFT;
                        shreg_q   <= load_w;
                        bit_cnt_q <= '0;
                        div_q     <= '0;
                        ready_q   <= 1'b0;
                        frame_q   <= 1'b1;
                        // First bit is visible the cycle after the accept.
                        ser_out_q <= load_w[NBITS-1];
                        strobe_q  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q     <= '0;
                        shreg_q   <= {shreg_q[NBITS-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q   <= ST_DONE;
                            frame_q   <= 1'b0;
                            ser_out_q <= 1'b0;
                            strobe_q  <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            // Registered output leads the shift: present the
                            // bit that will be at the MSB after this edge.
                            ser_out_q <= shreg_q[NBITS-2];
                            strobe_q  <= 1'b1;
                        end
                    end else begin
                        div_q    <= div_q + 1'b1;
                        strobe_q <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    ready_q   <= 1'b1;
                    ser_out_q <= 1'b0;
                    frame_q   <= 1'b0;
                    strobe_q  <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_frame  = frame_q;
    assign bus.bit_strobe = strobe_q;
    assign bus.done       = done_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_result_serializer
//   Two serializers share clock and reset: one with CLK_DIV=1 and one with
//   CLK_DIV=3. A task drives one word into the selected instance and compares
//   every frame cycle against a bit list built from the word itself.
// -----------------------------------------------------------------------------
module tb_result_serializer;

    localparam int WIDTH = 32;
`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    result_serializer_if #(.WIDTH(WIDTH)) a_if ();
    result_serializer_if #(.WIDTH(WIDTH)) b_if ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    result_serializer #(.WIDTH(WIDTH), .CLK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .dbg_state_o(dbg_a)
    );
    result_serializer #(.WIDTH(WIDTH), .CLK_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .dbg_state_o(dbg_b)
    );

    // Selected-instance view: sel=0 -> CLK_DIV=1, sel=1 -> CLK_DIV=3.
    logic             sel = 1'b0;
    logic             start_r = 1'b0;
    logic [WIDTH-1:0] data_r = '0;

    assign a_if.start   = start_r & ~sel;
    assign b_if.start   = start_r & sel;
    assign a_if.data_in = data_r;
    assign b_if.data_in = data_r;

    wire m_ready  = sel ? b_if.ready      : a_if.ready;
    wire m_ser    = sel ? b_if.ser_out    : a_if.ser_out;
    wire m_frame  = sel ? b_if.ser_frame  : a_if.ser_frame;
    wire m_strobe = sel ? b_if.bit_strobe : a_if.bit_strobe;
    wire m_done   = sel ? b_if.done       : a_if.done;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected serial bit list: data MSB to LSB, then even parity if enabled.
    task automatic build_expected(input logic [WIDTH-1:0] word);
        exp_q.delete();
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(1'($countones(word) % 2));
`endif
    endtask

    // ---------------- driver ----------------
    // busy   : pulse an ignored start on frame cycle 5 and on the done cycle
    // rst_at : frame cycle on which reset is asserted (-1 = never)
    task automatic run_frame(input logic s, input logic [WIDTH-1:0] word,
                             input bit busy, input int rst_at);
        int div;
        int total;
        int strobes;
        int waited;
        logic [NBITS-1:0] lb;
        logic [NBITS-1:0] lb_exp;

        sel = s;
        div = s ? 3 : 1;
        waited = 0;
        while (!m_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("idle_before_start", m_ready, 1);

        build_expected(word);
`ifdef SER_PARITY_EN
        lb_exp = {word, 1'($countones(word) % 2)};
`else
        lb_exp = word;
`endif

        start_r = 1'b1;
        data_r  = word;
        @(negedge clk);
        start_r = 1'b0;
        data_r  = $urandom;

        total   = NBITS * div;
        strobes = 0;
        lb      = '0;
        for (int k = 0; k < total; k++) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_frame_drop", m_frame, 0);
                check("rst_ready", m_ready, 1);
                check("rst_strobe", m_strobe, 0);
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    check("rst_no_done", m_done, 0);
                    check("rst_hold_ready", m_ready, 1);
                end
                rst_n = 1'b1;
                @(negedge clk);
                check("post_rst_no_done", m_done, 0);
                check("post_rst_frame", m_frame, 0);
                return;
            end
            check("frame", m_frame, 1);
            check("ser_out", m_ser, exp_q[k / div]);
            check("strobe", m_strobe, (k % div) == 0);
            check("busy_ready", m_ready, 0);
            check("early_done", m_done, 0);
            if (m_strobe) begin
                lb = {lb[NBITS-2:0], m_ser};
                strobes++;
            end
            if (busy && k == 5) begin
                start_r = 1'b1;
                data_r  = 32'h1234_5678;
            end
            if (busy && k == 6) start_r = 1'b0;
            @(negedge clk);
        end

        check("done_pulse", m_done, 1);
        check("done_frame", m_frame, 0);
        check("done_ser", m_ser, 0);
        check("done_ready", m_ready, 0);
        check("done_strobe", m_strobe, 0);
        check("loopback", lb, lb_exp);
        check("strobe_count", strobes, NBITS);
        if (busy) begin
            start_r = 1'b1;
            data_r  = 32'h1234_5678;
        end
        @(negedge clk);
        start_r = 1'b0;
        check("ready_after_done", m_ready, 1);
        check("single_done", m_done, 0);
        check("idle_frame", m_frame, 0);
        if (busy) begin
            @(negedge clk);
            check("busy_no_restart", m_frame, 0);
            check("busy_still_ready", m_ready, 1);
            check("busy_no_done", m_done, 0);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready_a", a_if.ready, 1);
        check("rst_ser_a", a_if.ser_out, 0);
        check("rst_frame_a", a_if.ser_frame, 0);
        check("rst_strobe_a", a_if.bit_strobe, 0);
        check("rst_done_a", a_if.done, 0);
        check("rst_ready_b", b_if.ready, 1);
        check("rst_frame_b", b_if.ser_frame, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame and explicit head of the bit stream.
        build_expected(32'hA5C3_0F01);
        check("head_bits", {exp_q[0], exp_q[1], exp_q[2], exp_q[3],
                            exp_q[4], exp_q[5], exp_q[6], exp_q[7]}, 8'b1010_0101);
        run_frame(1'b0, 32'hA5C3_0F01, 1'b0, -1);

        // Boundary sweep and random words.
        run_frame(1'b0, 32'h0000_0000, 1'b0, -1);
        run_frame(1'b0, 32'hFFFF_FFFF, 1'b0, -1);
        run_frame(1'b0, 32'h8000_0001, 1'b0, -1);
        run_frame(1'b0, 32'h0000_0003, 1'b0, -1);
        for (int i = 0; i < 100; i++) run_frame(1'b0, $urandom, 1'b0, -1);

        // Ignored starts while busy.
        run_frame(1'b0, 32'hA5C3_0F01, 1'b1, -1);

        // Divider instance.
        run_frame(1'b1, 32'hA5C3_0F01, 1'b0, -1);
        run_frame(1'b1, 32'hA5C3_0F01, 1'b1, -1);
        for (int i = 0; i < 4; i++) run_frame(1'b1, $urandom, 1'b0, -1);

        // Mid-frame reset, then a clean frame on the same instance.
        run_frame(1'b0, 32'hA5C3_0F01, 1'b0, 10);
        run_frame(1'b0, 32'h5A3C_F0E1, 1'b0, -1);
        run_frame(1'b1, 32'hDEAD_BEEF, 1'b0, 10);
        run_frame(1'b1, 32'h0F0F_1234, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d expected=%0d", 0, 1);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
